uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver that sits directly downstream of the `uart` transmitter. It consumes a TxD-style line (idle high, start bit low, LSB first, optional parity, one stop bit) and delivers each received character through a valid/ack holding register with error flags. Its configuration inputs mirror the transmitter's, so a loopback with the same `Freq_Divide_Param` and bit-length settings is bit-exact.

## Interface
- `SYNC_STAGES`, default 2: number of flops in the RxD_i synchroniser; must be ≥ 2.
- `m_clock` in 1: sole clock.
- `p_reset` in 1: asynchronous, active-low reset.
- `RxD_i` in 1: serial input, asynchronous to `m_clock`.
- `Freq_Divide_Param_i` in 16: m_clock cycles per bit (N); values below 4 clamp to 4.
- `Rx_BitLength_i` in 2: data bits; 00=5, 01=6, 10=7, 11=8.
- `Rx_ParityEN_i` in 1: a parity bit follows the data bits.
- `Rx_OddParity_i` in 1: 1=odd parity, 0=even parity.
- `Rx_Enable_i` in 1: 0 aborts any frame in progress and holds the FSM in IDLE.
- `Rx_Ack_i` in 1: consumer accepts the holding register.
- `Rx_Data_o` out 8: received data, LSB-aligned; unused upper bits are 0.
- `Rx_Valid_o` out 1: holding register is full.
- `Rx_ParityErr_o` out 1: parity mismatch for the held character.
- `Rx_FrameErr_o` out 1: stop bit sampled low for the held character.
- `Rx_Overrun_o` out 1: sticky; a character was lost while the holding register was full.
- `Rx_Busy_o` out 1: FSM is not in IDLE.

## Operation
- The synchroniser resets to 1. All FSM logic uses the synchronised line `rxs`.
- Configuration is latched on the IDLE→START transition and stays frozen for the rest of the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- Down-counter `cnt`, 16 bits. A "tick" is `cnt==0`. Any state that reloads sets `cnt = N-1`.
- IDLE: if `rxs==0` and `Rx_Enable_i==1`, go to START with `cnt = (N>>1)-1`.
- START: on tick, if `rxs==0`, go to DATA (reload). Otherwise the start was a glitch: go to IDLE with no output.
- DATA: on tick, shift `rxs` into bit `idx` (LSB first). After the last bit, go to PARITY if parity is enabled, else to STOP (reload).
- PARITY: on tick, compute `perr = (^data ^ rxs) != Rx_OddParity`, then go to STOP (reload).
- STOP: on tick, sample `rxs`, set `ferr = ~rxs`, and complete the frame.
  - Next state is IDLE if `rxs==1`.
  - Next state is BREAK if `rxs==0`.
- BREAK: wait for `rxs==1`, then go to IDLE. No new start is detected while in BREAK.
- Frame completion:
  - If `Rx_Valid_o==0` or `Rx_Ack_i==1`: load data, perr and ferr into the holding register; `Rx_Valid_o=1`.
  - Otherwise: the holding register is unchanged, the new character is dropped, and `Rx_Overrun_o` is set to 1.
- Ack:
  - `Rx_Ack_i` while `Rx_Valid_o==1` (and no completion in the same cycle) clears `Rx_Valid_o` and `Rx_Overrun_o`.
  - Ack while `Rx_Valid_o==0` is ignored.
- `Rx_Enable_i` low in any state: next state is IDLE, no completion, and the holding register is untouched.
- Reset values: `Rx_Data_o=0`, `Rx_Valid_o=0`, `Rx_ParityErr_o=0`, `Rx_FrameErr_o=0`, `Rx_Overrun_o=0`, `Rx_Busy_o=0`. State is IDLE.
- Assertion of `p_reset` mid-frame discards the frame immediately.

## Timing
- Start detection occurs `SYNC_STAGES` cycles after the RxD_i falling edge.
- The stop bit is sampled `(N>>1) + (D+P+1)*N` cycles after START entry, where D = number of data bits and P = 1 if parity is enabled.
- `Rx_Valid_o` rises in the cycle after the stop sample (registered).
- Every sample lands at bit centre ±1 cycle.
- IDLE is re-entered in the cycle after the stop sample, so back-to-back frames are accepted with zero extra idle time.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: PARITY state, `Rx_ParityEN_i` and `Rx_OddParity_i` are functional.
- Undefined:
  - the PARITY state and parity logic are not compiled;
  - `Rx_ParityEN_i` and `Rx_OddParity_i` are ignored and frames are always data+stop;
  - `Rx_ParityErr_o` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - rx state encoding;
  - bit-length codes (`BITLEN_5` .. `BITLEN_8`), shared with the transmitter;
  - `UART_MIN_DIVIDE = 4`.
- One sub-module, `uart_rx_sync`: a `SYNC_STAGES`-deep synchroniser with reset value 1.
- The FSM, counter, shifter and holding register all live in `uart_rx`.

## Test plan
- Loopback from `uart` with N=32, 8N1, data 0x38 → `Rx_Data_o=0x38`, `Rx_Valid_o` rises once, both error flags 0; repeat 256 values back-to-back with no loss.
- 7 data bits, odd parity, bit length 10, data 0x55 sent with a corrupted parity bit → `Rx_Data_o=0x55`, `Rx_ParityErr_o=1`.
- Line held low for 20 bit times → one character 0x00 with `Rx_FrameErr_o=1`, `Busy=1` until the line returns high, and no second character.
- Two frames with no Ack in between → `Rx_Data_o` = first byte and `Rx_Overrun_o=1`; Ack clears both `Valid` and `Overrun`. Ack coincident with the second completion → second byte held, no overrun.
- Low pulse of N/4 cycles on an idle line → START is entered, then IDLE; no valid is produced.
- `p_reset` asserted mid-DATA → all outputs 0 and state IDLE; the next full frame 0xA5 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, bit-length codes, divider floor.
// Used by uart_rx; bit-length codes are common with the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam logic [1:0] BITLEN_5 = 2'b00;
  localparam logic [1:0] BITLEN_6 = 2'b01;
  localparam logic [1:0] BITLEN_7 = 2'b10;
  localparam logic [1:0] BITLEN_8 = 2'b11;

  localparam logic [15:0] UART_MIN_DIVIDE = 16'd4;

  function automatic logic [15:0] clamp_div(
    input logic [15:0] n
  );
    return (n < UART_MIN_DIVIDE) ? UART_MIN_DIVIDE : n;
  endfunction

  // Index of the final data bit: code 00 -> 4 ... code 11 -> 7.
  function automatic logic [2:0] last_idx(
    input logic [1:0] bl
  );
    return {1'b1, bl};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line.
// Resets to 1 so an idle (high) line produces no false start.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the raw line through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM with a valid/ack holding register.
// Parity support is compiled only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        RxD_i,
  input  logic [15:0] Freq_Divide_Param_i,
  input  logic [1:0]  Rx_BitLength_i,
  input  logic        Rx_ParityEN_i,
  input  logic        Rx_OddParity_i,
  input  logic        Rx_Enable_i,
  input  logic        Rx_Ack_i,
  output logic [7:0]  Rx_Data_o,
  output logic        Rx_Valid_o,
  output logic        Rx_ParityErr_o,
  output logic        Rx_FrameErr_o,
  output logic        Rx_Overrun_o,
  output logic        Rx_Busy_o
);

  logic        rxs;
  rx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [15:0] n_q;
  logic [15:0] n_d;
  logic [1:0]  bl_q;
  logic [2:0]  idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferr_q;
  logic        ovr_q;
  logic        tick;
  logic        done_d;
`ifdef UART_RX_PARITY_EN
  logic        par_en_q;
  logic        odd_q;
  logic        perr_f_q;
  logic        perr_q;
`else
  logic        unused_par;
`endif

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (m_clock),
    .rst_ni (p_reset),
    .d_i    (RxD_i),
    .q_o    (rxs)
  );

  assign n_d    = clamp_div(Freq_Divide_Param_i);
  assign tick   = (cnt_q == 16'd0);
  assign done_d = Rx_Enable_i && (state_q == RX_STOP) && tick;

  // Frame FSM, bit timer, shifter and holding register.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      n_q      <= UART_MIN_DIVIDE;
      bl_q     <= BITLEN_8;
      idx_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      perr_f_q <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_q - 16'd1;
      if (Rx_Ack_i && valid_q && !done_d) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      if (!Rx_Enable_i) begin
        state_q <= RX_IDLE;
      end else begin
        unique case (state_q)
          RX_IDLE: begin
            if (!rxs) begin
              state_q  <= RX_START;
              cnt_q    <= (n_d >> 1) - 16'd1;
              n_q      <= n_d;
              bl_q     <= Rx_BitLength_i;
              idx_q    <= '0;
              shift_q  <= '0;
`ifdef UART_RX_PARITY_EN
              par_en_q <= Rx_ParityEN_i;
              odd_q    <= Rx_OddParity_i;
              perr_f_q <= 1'b0;
`endif
            end
          end
          RX_START: begin
            if (tick) begin
              cnt_q   <= n_q - 16'd1;
              state_q <= rxs ? RX_IDLE : RX_DATA;
            end
          end
          RX_DATA: begin
            if (tick) begin
              cnt_q          <= n_q - 16'd1;
              shift_q[idx_q] <= rxs;
              if (idx_q == last_idx(bl_q)) begin
`ifdef UART_RX_PARITY_EN
                state_q <= par_en_q ? RX_PARITY : RX_STOP;
`else
                state_q <= RX_STOP;
`endif
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          RX_PARITY: begin
            if (tick) begin
              cnt_q    <= n_q - 16'd1;
              perr_f_q <= ((^shift_q) ^ rxs) != odd_q;
              state_q  <= RX_STOP;
            end
          end
`endif
          RX_STOP: begin
            if (tick) begin
              if (!valid_q || Rx_Ack_i) begin
                data_q  <= shift_q;
                ferr_q  <= ~rxs;
                valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_q  <= perr_f_q;
`endif
              end else begin
                ovr_q <= 1'b1;
              end
              state_q <= rxs ? RX_IDLE : RX_BREAK;
            end
          end
          RX_BREAK: begin
            if (rxs) begin
              state_q <= RX_IDLE;
            end
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  assign Rx_Data_o     = data_q;
  assign Rx_Valid_o    = valid_q;
  assign Rx_FrameErr_o = ferr_q;
  assign Rx_Overrun_o  = ovr_q;
  assign Rx_Busy_o     = (state_q != RX_IDLE);
`ifdef UART_RX_PARITY_EN
  assign Rx_ParityErr_o = perr_q;
`else
  assign Rx_ParityErr_o = 1'b0;
  assign unused_par     = Rx_ParityEN_i ^ Rx_OddParity_i;
`endif

endmodule
